// File: rtl/control_sequencer_pkg.sv
// Shared constants for the control sequencer: opcodes, state encoding,
// ALU operation codes, instruction classes and the strobe bundle.
package control_sequencer_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_T7   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011
    } alu_op_t;

    typedef enum logic [3:0] {
        CL_RTYPE, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_BR, CL_JR, CL_NOP, CL_HALT
    } op_class_t;

    typedef struct packed {
        logic gra, grb, grc, rin, rout, ba_out;
        logic pc_out, pc_in, inc_pc, ir_in, mar_in, mdr_in, mdr_out;
        logic read, write, y_in, z_in, zlow_out, c_out, con_in;
    } strobes_t;

    function automatic alu_op_t rtype_alu(input logic [4:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_opcode_class.sv
// Combinational opcode-to-class map; undefined opcodes fold into CL_NOP.
module opcode_class
    import control_sequencer_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = CL_NOP;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = CL_RTYPE;
            OP_ADDI:                       op_class = CL_IMM;
            OP_LDI:                        op_class = CL_LDI;
            OP_LD:                         op_class = CL_LD;
            OP_ST:                         op_class = CL_ST;
            OP_BR:                         op_class = CL_BR;
            OP_JR:                         op_class = CL_JR;
            OP_HALT:                       op_class = CL_HALT;
            default:                       op_class = CL_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute control-step sequencer. Strobes are registered from the next
// state, so each cycle's strobes belong to the state shown on dbg_state.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Cout,
    output logic        CONin,
    output logic [3:0]  alu_op,
    output logic        run,
    output logic [3:0]  dbg_state
);

    op_class_t op_class;
    state_t    state, state_nx;
    logic      paused, paused_nx;
    strobes_t  str_q, str_nx;
    alu_op_t   alu_q, alu_nx;
    logic      run_q;
    logic      unused_ir;

    assign unused_ir = ^ir[26:0];

    opcode_class u_opcode_class (
        .opcode   (ir[31:27]),
        .op_class (op_class)
    );

    // A paused T0 (after clear or stop) issues no strobes; leaving it re-enters
    // an active T0 so the fetch always starts with its T0 strobes.
    always_comb begin
        state_nx  = state;
        paused_nx = 1'b0;
        case (state)
            S_T0: begin
                if (stop) begin
                    state_nx  = S_T0;
                    paused_nx = 1'b1;
                end else if (paused) begin
                    state_nx = S_T0;
                end else begin
                    state_nx = S_T1;
                end
            end
            S_T1: state_nx = S_T2;
            S_T2: begin
                case (op_class)
                    CL_NOP:  state_nx = S_T0;
                    CL_HALT: state_nx = S_HALT;
                    default: state_nx = S_T3;
                endcase
            end
            S_T3:    state_nx = (op_class == CL_JR) ? S_T0 : S_T4;
            S_T4:    state_nx = S_T5;
            S_T5:    state_nx = (op_class inside {CL_LD, CL_ST, CL_BR}) ? S_T6 : S_T0;
            S_T6:    state_nx = (op_class == CL_BR) ? S_T0 : S_T7;
            S_T7:    state_nx = S_T0;
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_T0;
        endcase
    end

    always_comb begin
        str_nx = '0;
        alu_nx = ALU_ADD;
        case (state_nx)
            S_T0: if (!paused_nx) begin
                str_nx.pc_out = 1'b1; str_nx.mar_in = 1'b1;
                str_nx.inc_pc = 1'b1; str_nx.z_in   = 1'b1;
            end
            S_T1: begin
                str_nx.zlow_out = 1'b1; str_nx.pc_in  = 1'b1;
                str_nx.read     = 1'b1; str_nx.mdr_in = 1'b1;
            end
            S_T2: begin
                str_nx.mdr_out = 1'b1; str_nx.ir_in = 1'b1;
            end
            S_T3: begin
                case (op_class)
                    CL_RTYPE, CL_IMM: begin str_nx.grb = 1'b1; str_nx.rout = 1'b1; str_nx.y_in = 1'b1; end
                    CL_LDI, CL_LD, CL_ST: begin str_nx.grb = 1'b1; str_nx.ba_out = 1'b1; str_nx.y_in = 1'b1; end
                    CL_BR: begin str_nx.gra = 1'b1; str_nx.rout = 1'b1; str_nx.con_in = 1'b1; end
                    CL_JR: begin str_nx.gra = 1'b1; str_nx.rout = 1'b1; str_nx.pc_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (op_class)
                    CL_RTYPE: begin
                        str_nx.grc = 1'b1; str_nx.rout = 1'b1; str_nx.z_in = 1'b1;
                        alu_nx = rtype_alu(ir[31:27]);
                    end
                    CL_IMM, CL_LDI, CL_LD, CL_ST: begin str_nx.c_out = 1'b1; str_nx.z_in = 1'b1; end
                    CL_BR: begin str_nx.pc_out = 1'b1; str_nx.y_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op_class)
                    CL_RTYPE, CL_IMM, CL_LDI: begin str_nx.zlow_out = 1'b1; str_nx.gra = 1'b1; str_nx.rin = 1'b1; end
                    CL_LD, CL_ST: begin str_nx.zlow_out = 1'b1; str_nx.mar_in = 1'b1; end
                    CL_BR: begin str_nx.c_out = 1'b1; str_nx.z_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (op_class)
                    CL_LD: begin str_nx.read = 1'b1; str_nx.mdr_in = 1'b1; end
                    CL_ST: begin str_nx.gra = 1'b1; str_nx.rout = 1'b1; str_nx.mdr_in = 1'b1; end
                    CL_BR: begin str_nx.zlow_out = 1'b1; str_nx.pc_in = con_ff; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (op_class)
                    CL_LD: begin str_nx.mdr_out = 1'b1; str_nx.gra = 1'b1; str_nx.rin = 1'b1; end
                    CL_ST: str_nx.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= S_T0;
            paused <= 1'b1;
            str_q  <= '0;
            alu_q  <= ALU_ADD;
            run_q  <= 1'b1;
        end else begin
            state  <= state_nx;
            paused <= paused_nx;
            str_q  <= str_nx;
            alu_q  <= alu_nx;
            run_q  <= (state_nx != S_HALT);
        end
    end

    assign Gra       = str_q.gra;
    assign Grb       = str_q.grb;
    assign Grc       = str_q.grc;
    assign Rin       = str_q.rin;
    assign Rout      = str_q.rout;
    assign BAout     = str_q.ba_out;
    assign PCout     = str_q.pc_out;
    assign PCin      = str_q.pc_in;
    assign IncPC     = str_q.inc_pc;
    assign IRin      = str_q.ir_in;
    assign MARin     = str_q.mar_in;
    assign MDRin     = str_q.mdr_in;
    assign MDRout    = str_q.mdr_out;
    assign Read      = str_q.read;
    assign Write     = str_q.write;
    assign Yin       = str_q.y_in;
    assign Zin       = str_q.z_in;
    assign Zlowout   = str_q.zlow_out;
    assign Cout      = str_q.c_out;
    assign CONin     = str_q.con_in;
    assign alu_op    = alu_q;
    assign run       = run_q;
    assign dbg_state = state;

endmodule
